// File: rtl/matrix_fm0dec.sv
// FM0 backscatter decoder: synchronizes rx_In, locks on the preamble, decodes N bits
// plus dummy-1 and reports done / error / collision / timeout as one-cycle pulses.
module matrix_fm0dec #(
  parameter logic [11:0] PREAMBLE = 12'b110100100011,
  parameter int unsigned MIN_HALF = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        rx_In,
  input  logic        rx_Enable,
  input  logic [15:0] r_Fm0HalfLen,
  input  logic [5:0]  r_RxBitLen,
  input  logic [31:0] r_RplyTimer,
  output logic        rx_Busy,
  output logic [31:0] rx_DataOut,
  output logic [5:0]  rx_BitCount,
  output logic        rx_Done,
  output logic        rx_RN16Received,
  output logic        rx_Error,
  output logic        rx_CollisionDetected,
  output logic        rx_Timeout
);
  // Protocol: rx_Enable is a level (high opens the window, low aborts silently);
  // exactly one registered status pulse ends each frame, with the FSM already in IDLE.
  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DATA, ST_DUMMY} state_t;

  state_t      r_state;
  logic        r_sync1, r_sync2, r_sync3;
  logic [15:0] r_ph;
  logic [11:0] r_hist;
  logic [31:0] r_tmo;
  logic        r_pair, r_h1, r_prev;
  logic [31:0] r_data;
  logic [5:0]  r_count;
  logic        r_done, r_rn16, r_err, r_coll, r_tmo_p;

  logic [15:0] w_h, w_mid, w_q1, w_q3;
  logic        w_edge, w_sample, w_half, w_bit, w_coll, w_ph_wrap, w_in_frame;
  logic [11:0] w_hist_next;
  logic [5:0]  w_n;
  logic [31:0] w_tmo_next;

  assign w_h         = (r_Fm0HalfLen < 16'(MIN_HALF)) ? 16'(MIN_HALF) : r_Fm0HalfLen;
  assign w_mid       = w_h >> 1;
  assign w_q1        = w_h >> 2;
  assign w_q3        = 16'(({2'b00, w_h} + {1'b0, w_h, 1'b0}) >> 2);
  assign w_edge      = r_sync2 ^ r_sync3;
  assign w_half      = r_sync2;
  assign w_sample    = (r_ph == w_mid);
  assign w_ph_wrap   = (r_ph >= w_h - 16'd1);
  assign w_hist_next = {r_hist[10:0], w_half};
  assign w_bit       = (r_h1 == w_half);
  assign w_n         = (r_RxBitLen == 6'd0) ? 6'd32 : r_RxBitLen;
  assign w_tmo_next  = (r_tmo == 32'hFFFF_FFFF) ? r_tmo : r_tmo + 32'd1;
  assign w_in_frame  = (r_state == ST_DATA) || (r_state == ST_DUMMY);
  // Legitimate edges land near half boundaries; one in the middle half-window is a second tag.
  assign w_coll      = w_in_frame && w_edge && (r_ph >= w_q1) && (r_ph < w_q3);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_ph    <= '0;
      r_hist  <= '0;
      r_tmo   <= '0;
      r_pair  <= 1'b0;
      r_h1    <= 1'b0;
      r_prev  <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_rn16  <= 1'b0;
      r_err   <= 1'b0;
      r_coll  <= 1'b0;
      r_tmo_p <= 1'b0;
    end else begin
      r_sync1 <= rx_In;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_done  <= 1'b0;
      r_rn16  <= 1'b0;
      r_err   <= 1'b0;
      r_coll  <= 1'b0;
      r_tmo_p <= 1'b0;
      r_ph    <= (w_edge || w_ph_wrap) ? 16'd0 : r_ph + 16'd1;
      if (w_sample) r_hist <= w_hist_next;

      if (!rx_Enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_SEARCH;
            r_data  <= '0;
            r_count <= '0;
            r_hist  <= '0;
            r_ph    <= '0;
            r_tmo   <= '0;
            r_pair  <= 1'b0;
          end
          ST_SEARCH: begin
            r_tmo <= w_tmo_next;
            if (w_sample && (w_hist_next == PREAMBLE)) begin
              r_state <= ST_DATA;
              r_prev  <= PREAMBLE[0];
              r_pair  <= 1'b0;
            end else if ((r_RplyTimer != 32'd0) && (w_tmo_next >= r_RplyTimer)) begin
              r_tmo_p <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
          ST_DATA, ST_DUMMY: begin
            if (w_coll) begin
              r_coll  <= 1'b1;
              r_state <= ST_IDLE;
            end else if (w_sample) begin
              if (!r_pair) begin
                // Every FM0 bit must start with an inversion of the previous half.
                if (w_half == r_prev) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
                end else begin
                  r_h1   <= w_half;
                  r_pair <= 1'b1;
                end
              end else begin
                r_pair <= 1'b0;
                if (r_state == ST_DATA) begin
                  r_data  <= {r_data[30:0], w_bit};
                  r_count <= r_count + 6'd1;
                  r_prev  <= w_half;
                  if (r_count + 6'd1 == w_n) r_state <= ST_DUMMY;
                end else if (w_bit) begin
                  r_done  <= 1'b1;
                  r_rn16  <= (w_n == 6'd16);
                  r_state <= ST_IDLE;
                end else begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
                end
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_Busy              = (r_state != ST_IDLE);
  assign rx_DataOut           = r_data;
  assign rx_BitCount          = r_count;
  assign rx_Done              = r_done;
  assign rx_RN16Received      = r_rn16;
  assign rx_Error             = r_err;
  assign rx_CollisionDetected = r_coll;
  assign rx_Timeout           = r_tmo_p;

endmodule

// File: tb/tb_matrix_fm0dec.sv
// Bench for matrix_fm0dec: an FM0 line encoder drives rx_In, status pulses are
// matched against an expected-result queue filled as each frame is launched.
module tb_matrix_fm0dec;
  localparam logic [11:0] PRE = 12'b110100100011;
  localparam int EW = 43;  // {kind[4:0], data[31:0], count[5:0]}

  logic        Clk;
  logic        Reset;
  logic        rx_In;
  logic        rx_Enable;
  logic [15:0] r_Fm0HalfLen;
  logic [5:0]  r_RxBitLen;
  logic [31:0] r_RplyTimer;
  logic        rx_Busy;
  logic [31:0] rx_DataOut;
  logic [5:0]  rx_BitCount;
  logic        rx_Done, rx_RN16Received, rx_Error, rx_CollisionDetected, rx_Timeout;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  bit          drv_abort;
  logic [4:0]  mon_v;
  logic [EW-1:0] mon_e;

  matrix_fm0dec dut (
    .Clk(Clk), .Reset(Reset), .rx_In(rx_In), .rx_Enable(rx_Enable),
    .r_Fm0HalfLen(r_Fm0HalfLen), .r_RxBitLen(r_RxBitLen), .r_RplyTimer(r_RplyTimer),
    .rx_Busy(rx_Busy), .rx_DataOut(rx_DataOut), .rx_BitCount(rx_BitCount),
    .rx_Done(rx_Done), .rx_RN16Received(rx_RN16Received), .rx_Error(rx_Error),
    .rx_CollisionDetected(rx_CollisionDetected), .rx_Timeout(rx_Timeout)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] rec(input logic [4:0] k, input logic [31:0] d, input logic [5:0] c);
    return {k, d, c};
  endfunction

  // scoreboard: pulse kinds are {timeout, collision, error, done, rn16}
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      mon_v = {rx_Timeout, rx_CollisionDetected, rx_Error, rx_Done, rx_RN16Received};
      if (mon_v != 5'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'(mon_v), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", 64'(mon_v), 64'(mon_e[42:38]));
          check("data_out", 64'(rx_DataOut), 64'(mon_e[37:6]));
          check("bit_count", 64'(rx_BitCount), 64'(mon_e[5:0]));
          check("busy_at_pulse", 64'(rx_Busy), 64'd0);
        end
      end
    end
  end

  // driver tasks
  task automatic send_frame(input logic [31:0] data, input int n, input int h, input bit dummy,
                            input int skip, input int glitch, input int jit);
    bit halves[$];
    bit wave[$];
    bit lvl, h1, h2;
    int run, dur, gpos;
    for (int i = 11; i >= 0; i--) halves.push_back(PRE[i]);
    lvl = 1'b1;
    for (int i = 0; i < n; i++) begin
      h1 = (i == skip) ? lvl : ~lvl;
      h2 = data[n-1-i] ? h1 : ~h1;
      halves.push_back(h1);
      halves.push_back(h2);
      lvl = h2;
    end
    h1 = ~lvl;
    h2 = dummy ? h1 : ~h1;
    halves.push_back(h1);
    halves.push_back(h2);
    run = 1;
    for (int i = 1; i <= halves.size(); i++) begin
      if (i < halves.size() && halves[i] == halves[i-1]) begin
        run++;
      end else begin
        dur = run * h;
        if (jit > 0) dur = dur + int'($urandom_range(2 * jit, 0)) - jit;
        repeat (dur) wave.push_back(halves[i-1]);
        run = 1;
      end
    end
    repeat (h) wave.push_back(halves[halves.size()-1]);
    if (glitch >= 0) begin
      gpos = (12 + 2 * glitch) * h + 10;
      for (int k = 0; k < 4; k++) wave[gpos+k] = ~wave[gpos+k];
    end
    for (int i = 0; i < wave.size(); i++) begin
      if (drv_abort) break;
      rx_In = wave[i];
      @(negedge Clk);
    end
  endtask

  task automatic start_rx(input logic [15:0] hl, input logic [5:0] nb, input logic [31:0] tmr);
    r_Fm0HalfLen = hl;
    r_RxBitLen   = nb;
    r_RplyTimer  = tmr;
    rx_In        = 1'b0;
    rx_Enable    = 1'b1;
    repeat (30) @(negedge Clk);
  endtask

  task automatic stop_rx();
    rx_Enable = 1'b0;
    rx_In     = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge Clk);
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic frame_case(input logic [31:0] data, input int n, input int h, input logic [15:0] hl_cfg,
                            input int jit);
    logic [31:0] m;
    m = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    start_rx(hl_cfg, 6'(n), 32'd0);
    exp_q.push_back(rec((n == 16) ? 5'b00011 : 5'b00010, data & m, 6'(n)));
    send_frame(data & m, n, h, 1'b1, -1, -1, jit);
    wait_drain(200);
    stop_rx();
  endtask

  initial begin
    int t_busy, t_pulse, n, h;
    logic [31:0] d;
    Reset = 1'b0; rx_In = 1'b0; rx_Enable = 1'b0; drv_abort = 1'b0;
    r_Fm0HalfLen = 16'd20; r_RxBitLen = 6'd16; r_RplyTimer = 32'd0;
    repeat (3) @(negedge Clk);
    check("rst_busy", 64'(rx_Busy), 64'd0);
    check("rst_data", 64'(rx_DataOut), 64'd0);
    check("rst_count", 64'(rx_BitCount), 64'd0);
    check("rst_pulses", 64'({rx_Timeout, rx_CollisionDetected, rx_Error, rx_Done, rx_RN16Received}), 64'd0);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check("idle_busy", 64'(rx_Busy), 64'd0);

    // RN16 decode
    start_rx(16'd20, 6'd16, 32'd0);
    check("search_busy", 64'(rx_Busy), 64'd1);
    exp_q.push_back(rec(5'b00011, 32'h0000A5C3, 6'd16));
    send_frame(32'hA5C3, 16, 20, 1'b1, -1, -1, 0);
    wait_drain(200);
    stop_rx();

    // reply timeout
    r_RplyTimer = 32'd1000;
    rx_In = 1'b0;
    exp_q.push_back(rec(5'b10000, 32'd0, 6'd0));
    rx_Enable = 1'b1;
    t_busy = -1;
    t_pulse = -1;
    for (int i = 1; i <= 3000 && t_pulse < 0; i++) begin
      @(negedge Clk);
      if (rx_Busy && t_busy < 0) t_busy = i;
      if (rx_Timeout) t_pulse = i;
    end
    stop_rx();
    check("tmo_seen", 64'(t_pulse > 0), 64'd1);
    check("tmo_latency", 64'((t_pulse - t_busy >= 999) && (t_pulse - t_busy <= 1001)), 64'd1);
    wait_drain(10);

    // timeout disabled
    r_RplyTimer = 32'd0;
    rx_Enable = 1'b1;
    repeat (10000) @(negedge Clk);
    check("no_tmo_busy", 64'(rx_Busy), 64'd1);
    stop_rx();

    // collision in bit 5
    d = $urandom_range(65535, 0);
    start_rx(16'd20, 6'd16, 32'd0);
    exp_q.push_back(rec(5'b01000, d >> 11, 6'd5));
    send_frame(d, 16, 20, 1'b1, -1, 5, 0);
    wait_drain(200);
    stop_rx();

    // missing boundary inversion before bit 3
    start_rx(16'd20, 6'd16, 32'd0);
    exp_q.push_back(rec(5'b00100, 32'd5, 6'd3));
    send_frame(32'hB234, 16, 20, 1'b1, 3, -1, 0);
    wait_drain(200);
    stop_rx();

    // dummy bit corrupted to 0
    start_rx(16'd20, 6'd8, 32'd0);
    exp_q.push_back(rec(5'b00100, 32'hC5, 6'd8));
    send_frame(32'hC5, 8, 20, 1'b0, -1, -1, 0);
    wait_drain(200);
    stop_rx();

    // asynchronous reset mid-DATA
    start_rx(16'd20, 6'd16, 32'd0);
    fork
      send_frame(32'h5A5A, 16, 20, 1'b1, -1, -1, 0);
      begin
        repeat (560) @(negedge Clk);
        check("pre_rst_busy", 64'(rx_Busy), 64'd1);
        check("pre_rst_data_nz", 64'(rx_DataOut != 32'd0), 64'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("midrst_busy", 64'(rx_Busy), 64'd0);
        check("midrst_data", 64'(rx_DataOut), 64'd0);
        check("midrst_count", 64'(rx_BitCount), 64'd0);
        drv_abort = 1'b1;
      end
    join
    drv_abort = 1'b0;
    rx_Enable = 1'b0;
    rx_In = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);

    // rx_Enable dropped mid-DATA
    start_rx(16'd20, 6'd16, 32'd0);
    fork
      send_frame(32'h3C3C, 16, 20, 1'b1, -1, -1, 0);
      begin
        repeat (560) @(negedge Clk);
        check("pre_abort_busy", 64'(rx_Busy), 64'd1);
        rx_Enable = 1'b0;
        drv_abort = 1'b1;
        repeat (2) @(negedge Clk);
        check("abort_busy", 64'(rx_Busy), 64'd0);
      end
    join
    drv_abort = 1'b0;
    stop_rx();

    // full 32-bit frame, clamped half length, jitter, random frames
    frame_case(32'hDEADBEEF, 32, 20, 16'd20, 0);
    frame_case(32'h9E71, 16, 8, 16'd3, 0);
    for (int k = 0; k < 3; k++) frame_case($urandom, 16, 20, 16'd20, 3);
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(32, 1);
      h = $urandom_range(24, 8);
      frame_case($urandom, n, h, 16'(h), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_fm0dec.md
# matrix_fm0dec

FM0 backscatter decoder for the tag-to-reader link. It is the receive counterpart of the PIE encoder/TX shift path. It samples the synchronized demodulated tag signal and locks onto the FM0 preamble. It then decodes a programmed number of data bits plus the dummy-1 and reports completion, coding errors, collisions and reply timeout to the inventory controller (drives `rx_RN16Received` / `rx_CollisionDetected`).

## Interface
Parameters:
- `PREAMBLE`, 12'b110100100011: FM0 preamble as 12 half-bit levels, MSB first (1 = high).
- `MIN_HALF`, 8: minimum usable half-bit length in Clk cycles.

Ports:
- `Clk`  in  1  single system clock; all logic on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `rx_In`  in  1  demodulated tag backscatter, asynchronous to Clk.
- `rx_Enable`  in  1  level; high = receive window open; low = abort to IDLE.
- `r_Fm0HalfLen`  in  16  nominal half-bit length in Clk cycles; values < MIN_HALF are used as MIN_HALF.
- `r_RxBitLen`  in  6  data bits expected, 1..32; 0 means 32.
- `r_RplyTimer`  in  32  preamble-search timeout in Clk cycles; 0 disables the timeout.
- `rx_Busy`  out  1  high in any state except IDLE.
- `rx_DataOut`  out  32  received bits, right-aligned, first bit most significant.
- `rx_BitCount`  out  6  data bits decoded so far.
- `rx_Done`  out  1  1-cycle pulse: frame including dummy-1 decoded cleanly.
- `rx_RN16Received`  out  1  1-cycle pulse, coincident with `rx_Done` when the bit length is 16.
- `rx_Error`  out  1  1-cycle pulse: FM0 coding violation.
- `rx_CollisionDetected`  out  1  1-cycle pulse: mid-half edge during data or dummy.
- `rx_Timeout`  out  1  1-cycle pulse: no preamble within `r_RplyTimer`.

## Operation
- **Synchronizer:** two-flop synchronizer on `rx_In`. The edge flag is the XOR of the synchronized value and its delayed copy.
- **Half-bit phase counter:** `ph`, width 16, with H = effective half length.
  - Resets to 0 on any edge.
  - Otherwise increments and wraps H-1 → 0.
  - A half sample is taken when `ph == H>>1` and is shifted into a 12-bit half-history register.
- **State machine:** IDLE, SEARCH, DATA, DUMMY.
  - IDLE: outputs idle. On `rx_Enable` rising (or held high after a terminal event plus one idle cycle) → SEARCH. This clears `rx_DataOut`, `rx_BitCount`, the history, `ph` and the timeout counter.
  - SEARCH:
    - Timeout counter increments every cycle.
    - If history == PREAMBLE on a sample cycle → DATA. The last preamble half (1) becomes `prev_half`.
    - If `r_RplyTimer != 0` and the counter reaches `r_RplyTimer` → `rx_Timeout` pulse, then IDLE.
  - DATA: halves are paired as (h1, h2).
    - h1 == `prev_half` (no boundary inversion) → `rx_Error`, then IDLE.
    - Otherwise bit = (h1 == h2), i.e. 1 if there is no mid-bit transition.
    - The bit is shifted into `rx_DataOut` at bit 0 and `rx_BitCount` increments. `prev_half` ← h2.
    - When count == N → DUMMY.
  - DUMMY: one more pair, which must have a boundary inversion and h1 == h2.
    - If so: `rx_Done` pulse, plus `rx_RN16Received` if N == 16, then IDLE.
    - Otherwise: `rx_Error`, then IDLE.
- **Collision:** in DATA or DUMMY, an edge with H>>2 ≤ `ph` < (3H)>>2 → `rx_CollisionDetected` pulse, then IDLE. `rx_DataOut` keeps its partial contents.
- **Priority on the same cycle:** collision > error > done. Timeout is only evaluated in SEARCH.
- **Abort:** `rx_Enable` low in any state → IDLE next cycle, with no pulses. `rx_DataOut` and `rx_BitCount` hold their values until the next SEARCH entry.
- **Reset:** asynchronous. All outputs go to 0 and the state goes to IDLE immediately, including mid-frame.

## Timing
- Input-edge to edge-flag latency is 2 Clk cycles. The first sample after an edge occurs H>>1 cycles later.
- A status pulse is registered: it appears the cycle after the deciding sample (or edge). The state is IDLE on that same cycle.
- Only one status pulse can occur per frame. All pulses are exactly one cycle wide.
- Minimum spacing between frames: one IDLE cycle.
- Arithmetic:
  - Comparisons use 16-bit unsigned `ph` against H-derived constants, truncated by shifts.
  - The timeout counter is 32-bit and saturates (never wraps).

## Test plan
- **RN16 decode:** H=20, N=16. Send PREAMBLE, FM0 0xA5C3, dummy-1 → `rx_DataOut` = 0x0000A5C3, `rx_BitCount` = 16, one cycle each of `rx_Done` and `rx_RN16Received`, no other pulses.
- **Timeout:** `r_RplyTimer` = 1000, line idle → `rx_Timeout` pulse 1000 cycles (±1) after SEARCH entry. With `r_RplyTimer` = 0 there is no timeout after 10000 cycles.
- **Collision:** H=20. Inject an extra edge 10 cycles into bit 5 → `rx_CollisionDetected` pulse, `rx_BitCount` = 5, no `rx_Done`.
- **Coding violation:** omit the boundary inversion before bit 3 → `rx_Error` pulse. Corrupt the dummy bit to 0 → `rx_Error`, with `rx_BitCount` = N.
- **Reset and abort:** assert `Reset` low mid-DATA → all outputs 0 immediately. Drop `rx_Enable` mid-DATA → IDLE, no pulses. Then a clean 32-bit frame 0xDEADBEEF (N=0) decodes correctly.
- **Clamp and jitter:** `r_Fm0HalfLen` = 3 with a signal at H = 8 → decodes correctly. With H = 20, ±3-cycle edge jitter → still decodes with no collision.
